cache_set: RTL and testbench

CACHE_SET -- requirements
Module: cache_set

---
 rtl/cache_pkg.sv | 14 +
 rtl/cache_way.sv | 52 +++++
 rtl/cache_set.sv | 173 +++++++++++++++++
 tb/tb_cache_set.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared request encoding and default geometry for the cache set.
package cache_pkg;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_FILL  = 2'b10,
        OP_INVAL = 2'b11
    } op_e;

    localparam int TAG_W_DEF = 19;
    localparam int BLK_W_DEF = 512;

endpackage

// File: rtl/cache_way.sv
// One way of the set: valid, dirty, tag and block registers.
// Fill installs a clean line, write marks it dirty, inval clears valid/dirty.
module cache_way
    import cache_pkg::*;
#(
    parameter int TAG_W = TAG_W_DEF,
    parameter int BLK_W = BLK_W_DEF
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             fill_i,
    input  logic             write_i,
    input  logic             inval_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic [BLK_W-1:0] blk_i,
    output logic             valid_o,
    output logic             dirty_o,
    output logic [TAG_W-1:0] tag_o,
    output logic [BLK_W-1:0] blk_o
);

    logic             valid_q;
    logic             dirty_q;
    logic [TAG_W-1:0] tag_q;
    logic [BLK_W-1:0] blk_q;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            valid_q <= 1'b0;
            dirty_q <= 1'b0;
            tag_q   <= '0;
            blk_q   <= '0;
        end else if (fill_i) begin
            valid_q <= 1'b1;
            dirty_q <= 1'b0;
            tag_q   <= tag_i;
            blk_q   <= blk_i;
        end else if (write_i) begin
            dirty_q <= 1'b1;
            blk_q   <= blk_i;
        end else if (inval_i) begin
            valid_q <= 1'b0;
            dirty_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign dirty_o = dirty_q;
    assign tag_o   = tag_q;
    assign blk_o   = blk_q;

endmodule

// File: rtl/cache_set.sv
// One set of a WAYS-way cache with age-based LRU and dirty write-back eviction.
// Registered response one cycle after each request; no backpressure.
module cache_set
    import cache_pkg::*;
#(
    parameter  int WAYS  = 4,
    parameter  int TAG_W = TAG_W_DEF,
    parameter  int BLK_W = BLK_W_DEF,
    localparam int AW    = $clog2(WAYS)
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             req_valid,
    input  logic [1:0]       req_op,
    input  logic [TAG_W-1:0] req_tag,
    input  logic [BLK_W-1:0] req_wdata,
    output logic             rsp_valid,
    output logic             rsp_hit,
    output logic [AW-1:0]    rsp_way,
    output logic [BLK_W-1:0] rsp_data,
    output logic             evict_valid,
    output logic [TAG_W-1:0] evict_tag,
    output logic [BLK_W-1:0] evict_data
);

    op_e              op;
    logic [WAYS-1:0]  way_vld, way_dirty, hit_vec;
    logic [WAYS-1:0]  fill_vec, write_vec, inval_vec;
    logic [TAG_W-1:0] way_tag [WAYS];
    logic [BLK_W-1:0] way_blk [WAYS];
    logic [AW-1:0]    age_q [WAYS];
    logic [AW-1:0]    age_d [WAYS];
    logic             hit, touch_en;
    logic [AW-1:0]    hit_way, victim, touch_way;

    logic             rsp_valid_q, rsp_hit_q, evict_valid_q;
    logic             rsp_valid_d, rsp_hit_d, evict_valid_d;
    logic [AW-1:0]    rsp_way_q, rsp_way_d;
    logic [BLK_W-1:0] rsp_data_q, rsp_data_d, evict_data_q, evict_data_d;
    logic [TAG_W-1:0] evict_tag_q, evict_tag_d;

    assign op = op_e'(req_op);

    for (genvar g = 0; g < WAYS; g++) begin : g_way
        cache_way #(.TAG_W(TAG_W), .BLK_W(BLK_W)) u_way (
            .clk     (clk),
            .rst_b   (rst_b),
            .fill_i  (fill_vec[g]),
            .write_i (write_vec[g]),
            .inval_i (inval_vec[g]),
            .tag_i   (req_tag),
            .blk_i   (req_wdata),
            .valid_o (way_vld[g]),
            .dirty_o (way_dirty[g]),
            .tag_o   (way_tag[g]),
            .blk_o   (way_blk[g])
        );
        assign hit_vec[g] = way_vld[g] && (way_tag[g] == req_tag);
    end

    assign hit = |hit_vec;

    always_comb begin
        hit_way = '0;
        for (int i = 0; i < WAYS; i++)
            if (hit_vec[i]) hit_way = AW'(i);
    end

    // Oldest way by default; a downward scan lets the lowest invalid way win.
    always_comb begin
        victim = '0;
        for (int i = 0; i < WAYS; i++)
            if (age_q[i] == AW'(WAYS - 1)) victim = AW'(i);
        for (int i = WAYS - 1; i >= 0; i--)
            if (!way_vld[i]) victim = AW'(i);
    end

    always_comb begin
        fill_vec      = '0;
        write_vec     = '0;
        inval_vec     = '0;
        touch_en      = 1'b0;
        touch_way     = hit_way;
        rsp_valid_d   = req_valid;
        rsp_hit_d     = 1'b0;
        rsp_way_d     = '0;
        rsp_data_d    = '0;
        evict_valid_d = 1'b0;
        evict_tag_d   = '0;
        evict_data_d  = '0;
        if (req_valid) begin
            rsp_hit_d = hit;
            rsp_way_d = hit_way;
            case (op)
                OP_READ: if (hit) begin
                    rsp_data_d = way_blk[hit_way];
                    touch_en   = 1'b1;
                end
                OP_WRITE: if (hit) begin
                    write_vec[hit_way] = 1'b1;
                    touch_en           = 1'b1;
                end
                OP_FILL: begin
                    touch_en = 1'b1;
                    if (hit) begin
                        fill_vec[hit_way] = 1'b1;
                    end else begin
                        fill_vec[victim] = 1'b1;
                        touch_way        = victim;
                        rsp_way_d        = victim;
                        if (way_vld[victim] && way_dirty[victim]) begin
                            evict_valid_d = 1'b1;
                            evict_tag_d   = way_tag[victim];
                            evict_data_d  = way_blk[victim];
                        end
                    end
                end
                OP_INVAL: if (hit) begin
                    inval_vec[hit_way] = 1'b1;
                    if (way_dirty[hit_way]) begin
                        evict_valid_d = 1'b1;
                        evict_tag_d   = way_tag[hit_way];
                        evict_data_d  = way_blk[hit_way];
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < WAYS; i++) begin
            age_d[i] = age_q[i];
            if (touch_en) begin
                if (AW'(i) == touch_way)
                    age_d[i] = '0;
                else if (age_q[i] < age_q[touch_way])
                    age_d[i] = age_q[i] + AW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < WAYS; i++) age_q[i] <= AW'(WAYS - 1 - i);
            rsp_valid_q   <= 1'b0;
            rsp_hit_q     <= 1'b0;
            rsp_way_q     <= '0;
            rsp_data_q    <= '0;
            evict_valid_q <= 1'b0;
            evict_tag_q   <= '0;
            evict_data_q  <= '0;
        end else begin
            for (int i = 0; i < WAYS; i++) age_q[i] <= age_d[i];
            rsp_valid_q   <= rsp_valid_d;
            rsp_hit_q     <= rsp_hit_d;
            rsp_way_q     <= rsp_way_d;
            rsp_data_q    <= rsp_data_d;
            evict_valid_q <= evict_valid_d;
            evict_tag_q   <= evict_tag_d;
            evict_data_q  <= evict_data_d;
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_hit     = rsp_hit_q;
    assign rsp_way     = rsp_way_q;
    assign rsp_data    = rsp_data_q;
    assign evict_valid = evict_valid_q;
    assign evict_tag   = evict_tag_q;
    assign evict_data  = evict_data_q;

endmodule

// File: tb/tb_cache_set.sv
// Directed scoreboard bench for cache_set (4 ways, 19-bit tags, 512-bit blocks).
module tb_cache_set;
    import cache_pkg::*;

    localparam int TW = 19;
    localparam int BW = 512;

    logic          clk, rst_b, req_valid;
    logic [1:0]    req_op;
    logic [TW-1:0] req_tag;
    logic [BW-1:0] req_wdata;
    logic          rsp_valid, rsp_hit, evict_valid;
    logic [1:0]    rsp_way;
    logic [BW-1:0] rsp_data, evict_data;
    logic [TW-1:0] evict_tag;

    cache_set dut (
        .clk         (clk),
        .rst_b       (rst_b),
        .req_valid   (req_valid),
        .req_op      (req_op),
        .req_tag     (req_tag),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_hit     (rsp_hit),
        .rsp_way     (rsp_way),
        .rsp_data    (rsp_data),
        .evict_valid (evict_valid),
        .evict_tag   (evict_tag),
        .evict_data  (evict_data)
    );

    typedef struct packed {
        logic          hit;
        logic [1:0]    way;
        logic [BW-1:0] data;
        logic          ev;
        logic [TW-1:0] etag;
        logic [BW-1:0] edata;
    } exp_t;

    exp_t  exq[$];
    string nmq[$];
    int    checks = 0;
    int    errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [BW-1:0] pat(input logic [31:0] w);
        return {16{w}};
    endfunction

    task automatic chk(input string nm, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", nm, got, exp);
        end
    endtask

    task automatic req(input logic [1:0] op, input logic [TW-1:0] tag, input logic [BW-1:0] wd,
                       input string nm, input logic hit, input logic [1:0] way,
                       input logic [BW-1:0] rd, input logic ev, input logic [TW-1:0] et,
                       input logic [BW-1:0] ed);
        exp_t e;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_tag   = tag;
        req_wdata = wd;
        e.hit = hit; e.way = way; e.data = rd;
        e.ev = ev; e.etag = et; e.edata = ed;
        exq.push_back(e);
        nmq.push_back(nm);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, ".rsp_valid"}, rsp_valid, 1'b0);
        chk({nm, ".rsp_hit"}, rsp_hit, 1'b0);
        chk({nm, ".rsp_way"}, rsp_way, 2'd0);
        chk({nm, ".rsp_data"}, rsp_data, '0);
        chk({nm, ".evict_valid"}, evict_valid, 1'b0);
        chk({nm, ".evict_tag"}, evict_tag, '0);
        chk({nm, ".evict_data"}, evict_data, '0);
    endtask

    // Monitor: every response must be expected and arrive exactly one cycle after its request.
    always @(posedge clk) begin
        exp_t  e;
        string nm;
        #1;
        if (rsp_valid) begin
            if (exq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_rsp got rsp_valid=1 exp 0");
            end else begin
                e  = exq.pop_front();
                nm = nmq.pop_front();
                chk({nm, ".hit"}, rsp_hit, e.hit);
                chk({nm, ".way"}, rsp_way, e.way);
                chk({nm, ".data"}, rsp_data, e.data);
                chk({nm, ".evict_valid"}, evict_valid, e.ev);
                chk({nm, ".evict_tag"}, evict_tag, e.etag);
                chk({nm, ".evict_data"}, evict_data, e.edata);
            end
        end else begin
            if (exq.size() != 0) begin
                checks++;
                errors++;
                nm = nmq.pop_front();
                e  = exq.pop_front();
                $display("FAIL %s.missing_rsp got rsp_valid=0 exp 1", nm);
            end
            chk("idle.evict_valid", evict_valid, 1'b0);
        end
    end

    initial begin
        rst_b     = 1'b0;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_tag   = '0;
        req_wdata = '0;
        #3;
        chk_zero("reset");
        repeat (2) @(negedge clk);
        rst_b = 1'b1;

        //   op        tag     wdata            name        hit way rdata            ev etag    edata
        req(OP_READ,  19'h1,  '0,              "rd_empty",  0, 0, '0,              0, '0,     '0);
        req(OP_FILL,  19'hA,  pat(32'hA0A0A0A0), "fill_a",  0, 0, '0,              0, '0,     '0);
        req(OP_FILL,  19'hB,  pat(32'hB0B0B0B0), "fill_b",  0, 1, '0,              0, '0,     '0);
        req(OP_FILL,  19'hC,  pat(32'hC0C0C0C0), "fill_c",  0, 2, '0,              0, '0,     '0);
        req(OP_FILL,  19'hD,  pat(32'hD0D0D0D0), "fill_d",  0, 3, '0,              0, '0,     '0);
        req(OP_READ,  19'hC,  '0,              "rd_c",      1, 2, pat(32'hC0C0C0C0), 0, '0,   '0);
        req(OP_WRITE, 19'hA,  pat(32'h55555555), "wr_a",    1, 0, '0,              0, '0,     '0);
        req(OP_FILL,  19'hE,  pat(32'hE0E0E0E0), "fill_e",  0, 1, '0,              0, '0,     '0);
        req(OP_FILL,  19'hF,  pat(32'hF0F0F0F0), "fill_f",  0, 3, '0,              0, '0,     '0);
        req(OP_INVAL, 19'hA,  '0,              "inv_a",     1, 0, '0,              1, 19'hA, pat(32'h55555555));
        req(OP_FILL,  19'h10, pat(32'h10101010), "fill_10", 0, 0, '0,              0, '0,     '0);
        req(OP_WRITE, 19'hC,  pat(32'h77777777), "wr_c",    1, 2, '0,              0, '0,     '0);
        req(OP_READ,  19'h10, '0,              "rd_10",     1, 0, pat(32'h10101010), 0, '0,   '0);
        req(OP_READ,  19'hE,  '0,              "rd_e",      1, 1, pat(32'hE0E0E0E0), 0, '0,   '0);
        req(OP_READ,  19'hF,  '0,              "rd_f",      1, 3, pat(32'hF0F0F0F0), 0, '0,   '0);
        req(OP_FILL,  19'h20, pat(32'h20202020), "fill_20", 0, 2, '0,              1, 19'hC, pat(32'h77777777));
        req(OP_WRITE, 19'h30, pat(32'h30303030), "wr_miss", 0, 0, '0,              0, '0,     '0);
        req(OP_INVAL, 19'h40, '0,              "inv_miss",  0, 0, '0,              0, '0,     '0);
        req(OP_READ,  19'h30, '0,              "rd_30",     0, 0, '0,              0, '0,     '0);
        idle(2);
        req(OP_FILL,  19'h10, pat(32'h11111111), "fill_hit", 1, 0, '0,             0, '0,     '0);
        req(OP_READ,  19'h10, '0,              "rd_10b",    1, 0, pat(32'h11111111), 0, '0,   '0);
        req(OP_WRITE, 19'hF,  pat(32'h99999999), "wr_f",    1, 3, '0,              0, '0,     '0);
        req(OP_READ,  19'hF,  '0,              "rd_f_b2b",  1, 3, pat(32'h99999999), 0, '0,   '0);
        req(OP_FILL,  19'h50, pat(32'h50505050), "fill_clean", 0, 1, '0,           0, '0,     '0);
        req(OP_WRITE, 19'h20, pat(32'hAAAAAAAA), "wr_20",   1, 2, '0,              0, '0,     '0);
        req(OP_FILL,  19'h20, pat(32'hBBBBBBBB), "refill_20", 1, 2, '0,            0, '0,     '0);
        req(OP_INVAL, 19'h20, '0,              "inv_20",    1, 2, '0,              0, '0,     '0);
        req(OP_INVAL, 19'hF,  '0,              "inv_f",     1, 3, '0,              1, 19'hF, pat(32'h99999999));
        req(OP_READ,  19'h10, '0,              "rd_pre_rst", 1, 0, pat(32'h11111111), 0, '0,  '0);

        // Request in flight when reset hits must never produce a response.
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = OP_READ;
        req_tag   = 19'h10;
        #2 rst_b  = 1'b0;
        #1;
        chk_zero("mid_reset");
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst_b = 1'b1;
        idle(4);

        req(OP_READ,  19'h10, '0,              "rd_after_rst", 0, 0, '0,           0, '0,     '0);
        req(OP_FILL,  19'h60, pat(32'h60606060), "fill_after_rst", 0, 0, '0,       0, '0,     '0);
        idle(3);

        for (int i = 0; i < 10 && exq.size() != 0; i++) @(posedge clk);
        chk("drain.pending", exq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
